// File: rtl/store_buf_pkg.sv
// Shared types for the posted store write buffer: buffered entry layout and drain states.
package store_buf_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int ENTRY_AW       = 5;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [31:0]         data;
  } store_entry_t;

  typedef enum logic {
    IDLE,
    WRITE
  } drain_state_t;

endpackage

// File: rtl/store_buf_fifo.sv
// Circular FIFO of buffered stores; exposes every slot plus a valid mask so the
// top can compare a load address against all pending entries in parallel.
module store_fifo
  import store_buf_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int EW    = $bits(store_entry_t)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  store_entry_t        push_entry,
  input  logic                pop,
  output store_entry_t        head,
  output logic [CW-1:0]       count,
  output logic [DEPTH*EW-1:0] entries_flat,
  output logic [DEPTH-1:0]    valid_mask
);

  store_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] offs;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem_q[rd_ptr];

  always_comb begin
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_flat[i*EW +: EW] = mem_q[i];
      offs                     = PW'(i) - rd_ptr;
      valid_mask[i]            = ({1'b0, offs} < count);
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted store buffer: queues 32-bit stores and drains them to byte-wide memory,
// MSB byte first, stalling any load that overlaps a still-pending store.
module store_write_buffer
  import store_buf_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  AW    = ENTRY_AW,
  parameter int  DW    = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int EW = $bits(store_entry_t);

  drain_state_t        state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d, issue_idx;
  logic                push, pop, issue;
  store_entry_t        push_entry, head, cmp_entry;
  logic [DEPTH*EW-1:0] entries_flat;
  logic [DEPTH-1:0]    valid_mask;
  logic [AW-1:0]       byte_addr_d, d_fwd, d_bwd;
  logic [7:0]          byte_d;
  logic                hit;

  assign st_ready   = (count != CW'(DEPTH));
  assign push       = st_valid && st_ready;
  assign push_entry = '{addr: st_addr, data: st_data};

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .head         (head),
    .count        (count),
    .entries_flat (entries_flat),
    .valid_mask   (valid_mask)
  );

  // A byte is issued on every edge that sees a committed entry, so consecutive
  // entries drain without a bubble; the head pops as its last byte is issued.
  assign issue = (count != '0);

  always_comb begin
    state_d    = IDLE;
    issue_idx  = (state_q == WRITE) ? byte_idx_q : 2'd0;
    byte_idx_d = byte_idx_q;
    pop        = 1'b0;
    if (issue) begin
      state_d    = WRITE;
      byte_idx_d = issue_idx + 2'd1;
      pop        = (issue_idx == 2'(BYTES_PER_WORD - 1));
    end
    byte_addr_d = head.addr + AW'(issue_idx);
    byte_d      = '0;
    unique case (issue_idx)
      2'd0: byte_d = head.data[31:24];
      2'd1: byte_d = head.data[23:16];
      2'd2: byte_d = head.data[15:8];
      2'd3: byte_d = head.data[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      if (issue) begin
        mem_addr  <= byte_addr_d;
        mem_wdata <= byte_d;
      end
    end
  end

  assign mem_we = (state_q == WRITE);
  assign empty  = (count == '0) && !mem_we;

  // Overlap is a modular distance of at most three bytes in either direction.
  always_comb begin
    hit       = 1'b0;
    cmp_entry = '0;
    d_fwd     = '0;
    d_bwd     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmp_entry = entries_flat[i*EW +: EW];
      d_fwd     = cmp_entry.addr - ld_addr;
      d_bwd     = ld_addr - cmp_entry.addr;
      if (valid_mask[i] && ((d_fwd <= AW'(BYTES_PER_WORD - 1)) ||
                            (d_bwd <= AW'(BYTES_PER_WORD - 1)))) begin
        hit = 1'b1;
      end
    end
    ld_stall = ld_valid && hit;
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drain order/latency, full handling,
// push-on-pop, address wrap, load overlap stalls and reset mid-drain.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [CW-1:0] count;
  logic          empty;

  int checks   = 0;
  int failures = 0;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_stall  (ld_stall),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert (count <= CW'(DEPTH))
      else begin
        failures++;
        $display("[TB] FAIL count_bound: got %0d, limit %0d", count, DEPTH);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                               input logic lv, input logic [AW-1:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectByte(input string tag, input logic [AW-1:0] a, input logic [7:0] d);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(a));
    checkOutput({tag, "_data"}, 32'(mem_wdata), 32'(d));
  endtask

  function automatic logic [31:0] pattern(input int k);
    return {8'(16*k), 8'(16*k + 1), 8'(16*k + 2), 8'(16*k + 3)};
  endfunction

  initial begin
    applyStimulus(1'b0, '0, '0, 1'b1, '0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_ready", 32'(st_ready), 32'd1);
    checkOutput("rst_stall", 32'(ld_stall), 32'd0);

    // Single store into an empty buffer
    applyStimulus(1'b1, 5'd4, 32'hAABBCCDD, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("single_count", 32'(count), 32'd1);
    checkOutput("single_we0", 32'(mem_we), 32'd0);
    checkOutput("single_empty0", 32'(empty), 32'd0);
    tick(); expectByte("single_b0", 5'd4, 8'hAA);
    tick(); expectByte("single_b1", 5'd5, 8'hBB);
    tick(); expectByte("single_b2", 5'd6, 8'hCC);
    tick(); expectByte("single_b3", 5'd7, 8'hDD);
    checkOutput("single_count_b3", 32'(count), 32'd0);
    checkOutput("single_empty_b3", 32'(empty), 32'd0);
    tick();
    checkOutput("single_done_we", 32'(mem_we), 32'd0);
    checkOutput("single_done_empty", 32'(empty), 32'd1);

    // Fill to full, hold a fifth store until space appears, drain 20 bytes
    applyStimulus(1'b1, 5'd0, pattern(0), 1'b0, '0);
    tick();
    for (int j = 0; j < 20; j++) begin
      int k;
      k = (j + 1 < 4) ? j + 1 : 4;
      if (j < 5) applyStimulus(1'b1, AW'(4*k), pattern(k), 1'b0, '0);
      else       applyStimulus(1'b0, '0, '0, 1'b0, '0);
      tick();
      expectByte($sformatf("burst_b%0d", j), AW'(j), 8'(16*(j/4) + (j%4)));
      if (j == 2) begin
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_ready", 32'(st_ready), 32'd0);
      end
      if (j == 3) begin
        checkOutput("held_count", 32'(count), 32'd3);
        checkOutput("held_ready", 32'(st_ready), 32'd1);
      end
      if (j == 4) begin
        checkOutput("fifth_count", 32'(count), 32'd4);
        checkOutput("fifth_ready", 32'(st_ready), 32'd0);
      end
    end
    tick();
    checkOutput("burst_done_we", 32'(mem_we), 32'd0);
    checkOutput("burst_done_empty", 32'(empty), 32'd1);

    // Push on the same edge the head pops
    applyStimulus(1'b1, 5'd20, pattern(5), 1'b0, '0);
    tick();
    applyStimulus(1'b1, 5'd24, pattern(6), 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("pp_count_pre", 32'(count), 32'd2);
    expectByte("pp_a0", 5'd20, 8'h50);
    tick(); expectByte("pp_a1", 5'd21, 8'h51);
    tick(); expectByte("pp_a2", 5'd22, 8'h52);
    applyStimulus(1'b1, 5'd28, pattern(7), 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    expectByte("pp_a3", 5'd23, 8'h53);
    checkOutput("pp_count_same", 32'(count), 32'd2);
    for (int j = 0; j < 8; j++) begin
      tick();
      expectByte($sformatf("pp_bc%0d", j), AW'(24 + j), 8'(16*(6 + j/4) + (j%4)));
    end
    tick();
    checkOutput("pp_done_empty", 32'(empty), 32'd1);

    // Address wrap, plus overlap across the wrap point
    applyStimulus(1'b1, 5'd30, 32'h11223344, 1'b1, 5'd1);
    #1;
    checkOutput("wrap_stall_samecycle", 32'(ld_stall), 32'd0);
    tick();
    checkOutput("wrap_stall_ld1", 32'(ld_stall), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd2);
    #1;
    checkOutput("wrap_stall_ld2", 32'(ld_stall), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    tick(); expectByte("wrap_b0", 5'd30, 8'h11);
    tick(); expectByte("wrap_b1", 5'd31, 8'h22);
    tick(); expectByte("wrap_b2", 5'd0, 8'h33);
    tick(); expectByte("wrap_b3", 5'd1, 8'h44);
    tick();
    checkOutput("wrap_done_we", 32'(mem_we), 32'd0);

    // Load overlap against a pending store at address 8
    applyStimulus(1'b1, 5'd8, 32'h01020304, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd10);
    #1; checkOutput("stall_ld10", 32'(ld_stall), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd12);
    #1; checkOutput("stall_ld12", 32'(ld_stall), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd5);
    #1; checkOutput("stall_ld5", 32'(ld_stall), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 5'd10);
    #1; checkOutput("stall_novalid", 32'(ld_stall), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd10);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("stall_drain%0d", i), 32'(ld_stall), (i < 3) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    tick();

    // Reset in the middle of draining, with two entries queued behind
    applyStimulus(1'b1, 5'd16, pattern(8), 1'b0, '0);
    tick();
    applyStimulus(1'b1, 5'd20, pattern(9), 1'b0, '0);
    tick();
    expectByte("mid_b0", 5'd16, 8'h80);
    applyStimulus(1'b1, 5'd24, pattern(10), 1'b0, '0);
    tick();
    expectByte("mid_b1", 5'd17, 8'h81);
    checkOutput("mid_count", 32'(count), 32'd3);
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_we", 32'(mem_we), 32'd0);
    checkOutput("mid_rst_empty", 32'(empty), 32'd1);
    checkOutput("mid_rst_addr", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("mid_quiet%0d", i), 32'(mem_we), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
